// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   state_t     : FSM state encoding
//   HALT_WORD   : ROM word that stops fetching (unmapped addresses read as zero)
//   PC_STEP_DEF : default sequential PC increment in bytes
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [31:0] HALT_WORD   = 32'h0000_0000;
  localparam int          PC_STEP_DEF = 4;

endpackage

// File: rtl/instr_fetch_ctrl_pc_unit.sv
// Program counter register with its next-PC mux.
// Ports:
//   clk, rst_n        : clock, async active-low reset (PC <- RESET_PC)
//   load_reset        : PC <- RESET_PC (start)
//   redirect          : PC <- redirect_pc with the low two bits cleared
//   advance           : PC <- PC + PC_STEP (wraps modulo 2^ADDR_W)
//   redirect_pc       : branch/jump target
//   pc                : current PC
// Priority: load_reset > redirect > advance > hold.
module pc_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_reset,
  input  logic              redirect,
  input  logic              advance,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load_reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      // Misaligned targets are truncated to a word boundary.
      pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (advance) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational instruction ROM
// and registers each fetched word with its PC into a valid/ready stage.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   start              : pulse; begin fetching at RESET_PC (IDLE or HALT only)
//   imem_addr          : ROM address (= PC register)
//   imem_instr         : ROM data, combinational from imem_addr
//   redirect_valid/pc  : branch/jump redirect, flushes the output stage
//   out_valid/ready    : handshake toward decode
//   out_instr, out_pc  : fetched word and its address
//   busy, halted       : state is FETCH / HALT
//   fetch_count        : completed handshakes since last start (saturating)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset; waits for start
// ST_FETCH | fetching one word per cycle when the output stage can accept
// ST_HALT  | zero word fetched; waits for start, ignores redirects
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = PC_STEP_DEF,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              pc_load_reset, pc_redirect, pc_advance;
  logic              out_valid_nxt;
  logic              out_capture;
  logic              cnt_clear;
  logic              xfer;

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_unit (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_reset  (pc_load_reset),
    .redirect    (pc_redirect),
    .advance     (pc_advance),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  assign imem_addr = pc;
  assign busy      = (state == ST_FETCH);
  assign halted    = (state == ST_HALT);
  // A transfer counts even when a redirect flushes the stage the same cycle.
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    pc_load_reset = 1'b0;
    pc_redirect   = 1'b0;
    pc_advance    = 1'b0;
    out_valid_nxt = out_valid;
    out_capture   = 1'b0;
    cnt_clear     = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt     = ST_FETCH;
          pc_load_reset = 1'b1;
          cnt_clear     = 1'b1;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_redirect   = 1'b1;
          out_valid_nxt = 1'b0;
        end else if (!out_valid || out_ready) begin
          if (imem_instr == HALT_WORD) begin
            out_valid_nxt = 1'b0;
            state_nxt     = ST_HALT;
          end else begin
            out_valid_nxt = 1'b1;
            out_capture   = 1'b1;
            pc_advance    = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      if (out_capture) begin
        out_instr <= imem_instr;
        out_pc    <= pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (cnt_clear) begin
      fetch_count <= '0;
    end else if (xfer && (fetch_count != '1)) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        halted;
  logic [15:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00: rom = 32'h512A4009;
      32'h04: rom = 32'h1234ABCD;
      32'h08: rom = 32'h518D581B;
      32'h0C: rom = 32'h51CF6824;
      32'h10: rom = 32'h00A00093;
      32'h14: rom = 32'h00208133;
      32'h18: rom = 32'h40110233;
      32'h1C: rom = 32'h0041A023;
      32'h20: rom = 32'hFE5214E3;
      32'h24: rom = 32'h9E950028;
      32'h28: rom = 32'h00C000EF;
      32'h2C: rom = 32'h00112623;
      32'h30: rom = 32'h00C12083;
      32'h34: rom = 32'h01010113;
      32'h38: rom = 32'h00008067;
      32'h3C: rom = 32'hDEADBEEF;
      32'h40: rom = 32'h0F0F0F0F;
      32'h44: rom = 32'h6C00006E;
      default: rom = 32'h0;
    endcase
  endfunction

  assign imem_instr = rom(imem_addr);

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    #12;
    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_no_start", 32'(busy), 32'd0);

    // Free run
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 18; i++) begin
      step();
      check("run_valid", 32'(out_valid), 32'd1);
      check("run_pc", out_pc, 32'(i * 4));
      check("run_instr", out_instr, rom(32'(i * 4)));
    end
    step();
    check("run_halted", 32'(halted), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_valid_end", 32'(out_valid), 32'd0);
    check("run_count", 32'(fetch_count), 32'd18);
    step();
    check("halt_hold_valid", 32'(out_valid), 32'd0);

    // Restart from HALT, then stall at 0x08
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_count", 32'(fetch_count), 32'd0);
    check("restart_addr", imem_addr, 32'h0);
    step(); step(); step();
    check("pre_stall_pc", out_pc, 32'h08);
    check("pre_stall_count", 32'(fetch_count), 32'd2);
    out_ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_instr", out_instr, 32'h518D581B);
      check("stall_pc", out_pc, 32'h08);
      check("stall_addr", imem_addr, 32'h0C);
      check("stall_count", 32'(fetch_count), 32'd2);
    end
    out_ready = 1'b1;
    step();
    check("release_pc", out_pc, 32'h0C);
    check("release_instr", out_instr, 32'h51CF6824);
    check("release_count", 32'(fetch_count), 32'd3);
    step();
    check("pre_rst_pc", out_pc, 32'h10);

    // Async reset mid-cycle
    rst_n = 1'b0;
    #2;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_instr", out_instr, 32'h0);
    check("arst_count", 32'(fetch_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Redirect to 0x44 while 0x04 is pending
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("refetch_pc", out_pc, 32'h00);
    check("refetch_instr", out_instr, 32'h512A4009);
    step();
    check("pend_pc", out_pc, 32'h04);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h44;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("redir_flush", 32'(out_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h44);
    check("redir_count", 32'(fetch_count), 32'd1);
    step();
    check("redir_tgt_valid", 32'(out_valid), 32'd1);
    check("redir_tgt_pc", out_pc, 32'h44);
    check("redir_tgt_instr", out_instr, 32'h6C00006E);
    step();
    check("redir_halted", 32'(halted), 32'd1);
    check("redir_final_count", 32'(fetch_count), 32'd2);

    // Redirect ignored in HALT
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    check("halt_redir_halted", 32'(halted), 32'd1);
    check("halt_redir_addr", imem_addr, 32'h48);

    // Misaligned redirect
    redirect_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h27;
    step();
    redirect_valid = 1'b0;
    check("misal_addr", imem_addr, 32'h24);
    check("misal_valid", 32'(out_valid), 32'd0);
    step();
    check("misal_pc", out_pc, 32'h24);
    check("misal_instr", out_instr, 32'h9E950028);
    check("misal_count", 32'(fetch_count), 32'd0);

    // Redirect coincident with a transfer still counts it
    redirect_valid = 1'b1; redirect_pc = 32'h00;
    step();
    redirect_valid = 1'b0;
    check("redir_xfer_count", 32'(fetch_count), 32'd1);
    check("redir_xfer_valid", 32'(out_valid), 32'd0);
    check("redir_xfer_addr", imem_addr, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
